// File: rtl/bcd_down_counter.sv
// ============================================================================
// Module   : bcd_down_counter
// Brief    : Multi-digit packed-BCD countdown timer with prescaler and a done
//            pulse. Optional macro BCD_DOWN_WRAP_EN enables periodic reload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_counter #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  pause,
   output logic [4*DIGITS-1:0]   q,
   output logic                  busy,
   output logic                  zero,
   output logic                  done
);

   localparam int W  = 4 * DIGITS;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    cnt, cnt_nxt;
   logic [PW-1:0]   presc, presc_nxt;
   logic            done_reg, done_nxt;
   logic [W-1:0]    load_clamped;
   logic [W-1:0]    cnt_dec;

   function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9)
            r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   // Ripple borrow: a zero digit receiving a borrow becomes 9 and passes it up.
   function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign load_clamped = clamp_bcd(load_val);
   assign cnt_dec      = dec_bcd(cnt);

`ifdef BCD_DOWN_WRAP_EN
   logic [W-1:0] reload;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         reload <= '0;
      else if (load)
         reload <= load_clamped;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         presc    <= '0;
         done_reg <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         presc    <= presc_nxt;
         done_reg <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      presc_nxt = presc;
      done_nxt  = 1'b0;

      if (load) begin
         cnt_nxt   = load_clamped;
         state_nxt = S_IDLE;
         presc_nxt = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!pause && start) begin
                  presc_nxt = '0;
                  if (cnt != '0) begin
                     state_nxt = S_RUN;
                  end else begin
                     state_nxt = S_DONE;
                     done_nxt  = 1'b1;
                  end
               end
            end

            S_RUN: begin
               if (pause) begin
                  state_nxt = S_HOLD;
               end else if (presc == PRESC_LAST) begin
                  presc_nxt = '0;
                  cnt_nxt   = cnt_dec;
                  if (cnt_dec == '0) begin
                     done_nxt = 1'b1;
`ifdef BCD_DOWN_WRAP_EN
                     if (reload != '0)
                        cnt_nxt = reload;
                     else
                        state_nxt = S_DONE;
`else
                     state_nxt = S_DONE;
`endif
                  end
               end else begin
                  presc_nxt = presc + PW'(1);
               end
            end

            S_HOLD: begin
               if (!pause && start)
                  state_nxt = S_RUN;
            end

            S_DONE: begin
               state_nxt = S_DONE;
            end

            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign q    = cnt;
   assign busy = (state == S_RUN);
   assign zero = (cnt == '0);
   assign done = done_reg;

endmodule

`default_nettype wire

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Multi-digit BCD down-counter (countdown timer); the counting-down counterpart of the team's BCD up-counter.
- Loads a packed BCD value, decrements once per prescaled tick while running, and flags zero with a one-cycle `done` pulse.
- Feeds the same display/digit consumers as the up-counter, using the same packed-nibble output format.

Parameters:
- DIGITS, 4, number of BCD digits; digit 0 is the least significant, in q[3:0].
- PRESCALE, 1, clocks per decrement tick (1 = decrement every clock while running); must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  synchronous load strobe; highest priority.
- load_val  in  4*DIGITS  packed BCD load value.
- start  in  1  begin or resume counting.
- pause  in  1  suspend counting.
- q  out  4*DIGITS  current count, packed BCD.
- busy  out  1  high in RUN state.
- zero  out  1  high when q is all zeros (combinational from q).
- done  out  1  one-cycle pulse when the count reaches zero.

Behaviour:
- Reset (reset = 0, asynchronous):
  - q = 0, state = IDLE, prescaler = 0, done = 0, busy = 0, zero = 1.
  - Reset asserted mid-RUN aborts immediately; there is no pending done.
- States: IDLE, RUN, HOLD, DONE.
- Priority each cycle: load > pause > start > tick.
- load (any state):
  - q <= load_val, with each nibble above 9 clamped to 9.
  - state <= IDLE; prescaler cleared; no done pulse.
- IDLE:
  - start with q != 0 -> RUN; prescaler cleared.
  - start with q == 0 -> DONE; done pulses on the next cycle.
- RUN:
  - pause -> HOLD; q and prescaler are frozen.
  - Otherwise the prescaler increments. At PRESCALE-1 it wraps to 0 and a tick occurs.
  - First decrement lands PRESCALE clocks after the start edge.
- HOLD:
  - start -> RUN, prescaler resumes from its held value.
  - start and pause both high: pause wins, stay in HOLD.
- Tick (decrement), ripple borrow:
  - Digit 0 decrements.
  - Any digit at 0 that receives a borrow becomes 9 and passes the borrow upward.
  - A tick that makes q == 0 transitions to DONE and asserts done for exactly that one cycle, registered with the q update.
- DONE:
  - q holds 0, busy = 0; start is ignored (load required).
- busy = 1 only in RUN. done is never high in two consecutive cycles.
- Underflow is impossible: q == 0 never receives a tick.
- Latency: load_val -> q is 1 clock. Tick -> q is updated on the same edge.

Optional Feature:
- Macro: BCD_DOWN_WRAP_EN.
- Defined:
  - The last load value is kept in a reload register.
  - On the tick reaching zero, done pulses, q <= reload value, and state stays RUN (periodic timer).
  - If the reload value is 0, the block enters DONE as in the base behaviour.
- Undefined:
  - No reload register; reaching zero always enters DONE.

Test Plan:
- Reset low mid-run with q = 0x0042 -> q = 0x0000, busy = 0, done = 0 immediately, without waiting for a clock edge.
- DIGITS = 4, PRESCALE = 1: load 0x0103, start -> q sequence 0103, 0102, 0101, 0100, 0099, 0098 on successive clocks; borrow chain verified.
- load 0x0002, start, PRESCALE = 3 -> q = 0001 three clocks after start, 0000 at six clocks; done high for that single cycle, busy falls, state DONE; a further start leaves q = 0000.
- RUN from 0x0050, pause for 10 clocks -> q constant, busy = 0; then start -> decrements resume with the prescaler phase preserved; start+pause together -> remains HOLD.
- load 0x00AF -> q = 0x0099 (clamped); load during RUN at q = 0x0030 -> q = load_val, state IDLE, no done.
- With BCD_DOWN_WRAP_EN: load 0x0002, start -> q 0001, 0000 → reload, i.e. q goes 0002, 0001, 0002, 0001, …; done pulses every 2 ticks; busy stays 1. Start with 0x0000 -> done once, then DONE state.
